// File: rtl/seq_array_mult.sv
// Sequential shift-add multiplier: one partial-product row per clock, valid/ready on both sides.
// Optional two's-complement mode enabled by defining MULT_SIGNED_EN (adds the is_signed port).
module seq_array_mult #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MULT_SIGNED_EN
    input  logic               is_signed,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mc_q, mc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CNT_W-1:0]     row_q, row_d;
    logic                 sgn_q, sgn_d;
    logic                 last_row;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   m_ext;
    logic                 sgn_in;

`ifdef MULT_SIGNED_EN
    assign sgn_in = is_signed;
`else
    assign sgn_in = 1'b0;
`endif

    assign m_ext    = sgn_in ? {{WIDTH{m[WIDTH-1]}}, m} : {{WIDTH{1'b0}}, m};
    assign last_row = (row_q == CNT_W'(WIDTH - 1));
    assign addend   = q_q[0] ? mc_q : '0;

    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        q_d     = q_q;
        acc_d   = acc_q;
        p_d     = p_q;
        row_d   = row_q;
        sgn_d   = sgn_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mc_d    = m_ext;
                    q_d     = q;
                    sgn_d   = sgn_in;
                    acc_d   = '0;
                    row_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Signed mode: the multiplier's MSB carries negative weight, so subtract that row.
                if (last_row && sgn_q) begin
                    acc_d = acc_q - addend;
                end else begin
                    acc_d = acc_q + addend;
                end
                mc_d  = mc_q << 1;
                q_d   = q_q >> 1;
                row_d = row_q + CNT_W'(1);
                if (last_row) begin
                    p_d     = acc_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mc_q    <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            row_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            row_q   <= row_d;
            sgn_q   <= sgn_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StBusy);
    assign out_valid = (state_q == StDone);
    assign p         = p_q;

endmodule
